// File: rtl/router_pkg.sv
// Shared definitions for the packet router: header field widths and the
// packet-writer FSM state type.
package router_pkg;

   localparam int ADDR_W = 8;
   localparam int LEN_W  = 8;

   typedef enum logic [1:0] {
      GET_ADDR    = 2'd0,
      GET_LEN     = 2'd1,
      GET_PAYLOAD = 2'd2
   } state_t;

   // Anything at or below 1 ends the packet, so a corrupted zero can never wrap.
   function automatic logic is_last(input logic [LEN_W-1:0] cnt);
      return (cnt <= LEN_W'(1));
   endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit incrementer that sticks at 16'hFFFF; async active-high reset.
module sat_cnt16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_inc,
   output logic [15:0] o_count
);

   logic [15:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= 16'd0;
      end else if (i_inc && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pkt_write.sv
// Splits an address/length/payload byte stream into a header FIFO word and
// payload FIFO bytes. Define PKT_STATS_EN to add pkt_count/drop_count.
module pkt_write
   import router_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [7:0]              in_data,
   output logic                    in_ready,
   input  logic                    fifo1_full,
   input  logic                    fifo2_full,
   output logic                    fifo1_wen,
   output logic [LEN_W+ADDR_W-1:0] fifo1_dataout,
   output logic                    fifo2_wen,
   output logic [7:0]              fifo2_dataout,
   output logic                    busy,
   output logic                    len_err
`ifdef PKT_STATS_EN
   ,
   output logic [15:0]             pkt_count,
   output logic [15:0]             drop_count
`endif
);

   state_t             r_state;
   logic [LEN_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]  r_addr;

   logic w_xfer;
   logic w_len_zero;

   assign w_xfer     = in_valid && in_ready;
   assign w_len_zero = (in_data == 8'd0);

   // Strobes are decoded straight from the transfer so a byte lands in its FIFO
   // in the same cycle it is accepted.
   always_comb begin
      in_ready  = 1'b0;
      fifo1_wen = 1'b0;
      fifo2_wen = 1'b0;
      len_err   = 1'b0;
      case (r_state)
         GET_ADDR: begin
            in_ready = 1'b1;
         end
         GET_LEN: begin
            in_ready  = !fifo1_full;
            fifo1_wen = in_valid && !fifo1_full && !w_len_zero;
            len_err   = in_valid && !fifo1_full && w_len_zero;
         end
         GET_PAYLOAD: begin
            in_ready  = !fifo2_full;
            fifo2_wen = in_valid && !fifo2_full;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign fifo1_dataout = {in_data, r_addr};
   assign fifo2_dataout = in_data;
   assign busy          = (r_state != GET_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= GET_ADDR;
         r_cnt   <= '0;
         r_addr  <= '0;
      end else if (w_xfer) begin
         case (r_state)
            GET_ADDR: begin
               r_addr  <= in_data;
               r_state <= GET_LEN;
            end
            GET_LEN: begin
               if (w_len_zero) begin
                  r_state <= GET_ADDR;
               end else begin
                  r_cnt   <= in_data;
                  r_state <= GET_PAYLOAD;
               end
            end
            GET_PAYLOAD: begin
               r_cnt <= (r_cnt == '0) ? '0 : r_cnt - LEN_W'(1);
               if (is_last(r_cnt)) begin
                  r_state <= GET_ADDR;
               end
            end
            default: begin
               r_state <= GET_ADDR;
            end
         endcase
      end
   end

`ifdef PKT_STATS_EN
   logic w_pkt_done;

   assign w_pkt_done = fifo2_wen && is_last(r_cnt);

   sat_cnt16 u_pkt_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_pkt_done),
      .o_count (pkt_count)
   );

   sat_cnt16 u_drop_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (len_err),
      .o_count (drop_count)
   );
`endif

endmodule

// File: tb/tb_pkt_write.sv
// Directed bench for pkt_write; FIFO writes are captured into queues by a
// negedge monitor and compared against hand-computed expectations.
module tb_pkt_write;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        fifo1_full = 1'b0;
   logic        fifo2_full = 1'b0;
   logic        fifo1_wen;
   logic [15:0] fifo1_dataout;
   logic        fifo2_wen;
   logic [7:0]  fifo2_dataout;
   logic        busy;
   logic        len_err;
`ifdef PKT_STATS_EN
   logic [15:0] pkt_count;
   logic [15:0] drop_count;
`endif

   int n_vec = 0;
   int n_bad = 0;

   logic [15:0] q1[$];
   logic [7:0]  q2[$];
   int          n_lenerr = 0;
   int          n_both = 0;

   pkt_write dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_ready      (in_ready),
      .fifo1_full    (fifo1_full),
      .fifo2_full    (fifo2_full),
      .fifo1_wen     (fifo1_wen),
      .fifo1_dataout (fifo1_dataout),
      .fifo2_wen     (fifo2_wen),
      .fifo2_dataout (fifo2_dataout),
      .busy          (busy),
      .len_err       (len_err)
`ifdef PKT_STATS_EN
      ,
      .pkt_count     (pkt_count),
      .drop_count    (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fifo1_wen) q1.push_back(fifo1_dataout);
      if (fifo2_wen) q2.push_back(fifo2_dataout);
      if (len_err) n_lenerr++;
      if (fifo1_wen && fifo2_wen) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      q1.delete();
      q2.delete();
      n_lenerr = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 200) begin
            chk("send_timeout", 32'(b), 32'hFFFF_FFFF);
            done = 1'b1;
         end
      end
   endtask

   task automatic idle(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_f1wen", 32'(fifo1_wen), 32'd0);
      chk("reset_f2wen", 32'(fifo2_wen), 32'd0);
      chk("reset_lenerr", 32'(len_err), 32'd0);
`ifdef PKT_STATS_EN
      chk("reset_pkt_count", 32'(pkt_count), 32'd0);
      chk("reset_drop_count", 32'(drop_count), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_log();

      // basic packet with an idle gap in the payload
      send_byte(8'h40);
      chk("p1_busy_after_addr", 32'(busy), 32'd1);
      send_byte(8'h03);
      send_byte(8'hA1);
      idle(2);
      chk("p1_hold_busy", 32'(busy), 32'd1);
      chk("p1_hold_nowrite", 32'(q2.size()), 32'd1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      in_valid = 1'b0;
      #1;
      chk("p1_busy_end", 32'(busy), 32'd0);
      chk("p1_f1_count", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) chk("p1_hdr", 32'(q1[0]), 32'h0340);
      chk("p1_f2_count", 32'(q2.size()), 32'd3);
      if (q2.size() == 3) begin
         chk("p1_pay0", 32'(q2[0]), 32'hA1);
         chk("p1_pay1", 32'(q2[1]), 32'hA2);
         chk("p1_pay2", 32'(q2[2]), 32'hA3);
      end
      idle(1);
      clear_log();

      // zero-length drop
      send_byte(8'hC8);
      send_byte(8'h00);
      idle(1);
      chk("p2_no_f1", 32'(q1.size()), 32'd0);
      chk("p2_no_f2", 32'(q2.size()), 32'd0);
      chk("p2_lenerr_pulses", 32'(n_lenerr), 32'd1);
      chk("p2_busy", 32'(busy), 32'd0);
`ifdef PKT_STATS_EN
      chk("p2_drop_count", 32'(drop_count), 32'd1);
`endif
      clear_log();

      // payload FIFO full stall
      send_byte(8'h11);
      send_byte(8'h03);
      send_byte(8'hB1);
      fifo2_full = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'hB2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("p3_stall_ready", 32'(in_ready), 32'd0);
         chk("p3_stall_wen", 32'(fifo2_wen), 32'd0);
         @(posedge clk);
         #1;
      end
      fifo2_full = 1'b0;
      send_byte(8'hB2);
      send_byte(8'hB3);
      in_valid = 1'b0;
      #1;
      chk("p3_f2_count", 32'(q2.size()), 32'd3);
      if (q2.size() == 3) begin
         chk("p3_pay0", 32'(q2[0]), 32'hB1);
         chk("p3_pay1", 32'(q2[1]), 32'hB2);
         chk("p3_pay2", 32'(q2[2]), 32'hB3);
      end
      chk("p3_busy_end", 32'(busy), 32'd0);
      clear_log();

      // header FIFO full stall on the length byte
      send_byte(8'h22);
      fifo1_full = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h02;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("p4_stall_ready", 32'(in_ready), 32'd0);
         chk("p4_stall_wen", 32'(fifo1_wen), 32'd0);
         @(posedge clk);
         #1;
      end
      chk("p4_stall_busy", 32'(busy), 32'd1);
      fifo1_full = 1'b0;
      send_byte(8'h02);
      send_byte(8'hC1);
      send_byte(8'hC2);
      in_valid = 1'b0;
      #1;
      chk("p4_f1_count", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) chk("p4_hdr", 32'(q1[0]), 32'h0222);
      chk("p4_f2_count", 32'(q2.size()), 32'd2);
      clear_log();

      // reset mid-packet, then a fresh packet
      send_byte(8'h33);
      send_byte(8'h05);
      send_byte(8'hD1);
      send_byte(8'hD2);
      chk("p5_busy_before_rst", 32'(busy), 32'd1);
      do_reset();
      clear_log();
      send_byte(8'h80);
      send_byte(8'h01);
      send_byte(8'h55);
      in_valid = 1'b0;
      #1;
      chk("p5_f1_count", 32'(q1.size()), 32'd1);
      if (q1.size() > 0) chk("p5_hdr", 32'(q1[0]), 32'h0180);
      chk("p5_f2_count", 32'(q2.size()), 32'd1);
      if (q2.size() > 0) chk("p5_pay", 32'(q2[0]), 32'h55);
      chk("p5_busy_end", 32'(busy), 32'd0);

      // back-to-back L=255 then L=1 with in_valid held high
      do_reset();
      clear_log();
      send_byte(8'h44);
      send_byte(8'hFF);
      for (int i = 0; i < 255; i++) send_byte(8'(i));
      send_byte(8'h45);
      send_byte(8'h01);
      send_byte(8'hEE);
      in_valid = 1'b0;
      #1;
      chk("p6_f1_count", 32'(q1.size()), 32'd2);
      if (q1.size() == 2) begin
         chk("p6_hdr0", 32'(q1[0]), 32'hFF44);
         chk("p6_hdr1", 32'(q1[1]), 32'h0145);
      end
      chk("p6_f2_count", 32'(q2.size()), 32'd256);
      if (q2.size() == 256) begin
         for (int i = 0; i < 255; i++) chk("p6_pay", 32'(q2[i]), 32'(i));
         chk("p6_pay_last", 32'(q2[255]), 32'hEE);
      end
      chk("p6_busy_end", 32'(busy), 32'd0);
`ifdef PKT_STATS_EN
      chk("p6_pkt_count", 32'(pkt_count), 32'd2);
`endif

      chk("wen_exclusive", 32'(n_both), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
